dat_line_xfer: RTL and testbench

- Line-transfer sequencer sitting directly upstream of the per-way data RAM array; it is the sole driver of that array's en/wen/addr/wdata command port and the sole consumer of its per-way read data.
- Fill: streams one cache line of beats from the refill path into a selected way.
- Evict: reads one line out of a selected way, beat by beat, and presents it on a valid/ready stream to the write-back path.
- One request is in flight at a time; the block is blocking, matching the cache.

---
 rtl/dat_line_xfer_pkg.sv | 36 +++
 rtl/dat_line_xfer_if.sv | 51 +++++
 rtl/xfer_skid_fifo.sv | 53 +++++
 rtl/dat_line_xfer.sv | 158 +++++++++++++++
 tb/tb_dat_line_xfer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dat_line_xfer_pkg.sv
// Shared types and sizing for the line-transfer sequencer and the per-way data RAM array.
// Way/beat geometry lives here so the RAM typedefs and the sequencer cannot drift apart.
package dat_line_xfer_pkg;

  localparam int unsigned WAYS_N  = 4;
  localparam int unsigned BEATS_N = 4;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned DAT_W   = 32;
  localparam int unsigned BEAT_W  = $clog2(BEATS_N);
  // One extra bit so a counter can hold BEATS_N itself.
  localparam int unsigned CNT_W   = BEAT_W + 1;
  localparam int unsigned ADDR_W  = IDX_W + BEAT_W;

  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [CNT_W-1:0]  beat_cnt_t;
  typedef logic [IDX_W-1:0]  line_idx_t;
  typedef logic [ADDR_W-1:0] cache_line_off_t;
  typedef logic [WAYS_N-1:0] way_sel_t;
  typedef logic [DAT_W-1:0]  ram_word_t;

  typedef enum logic {
    OpFill  = 1'b0,
    OpEvict = 1'b1
  } xfer_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StEvict
  } xfer_state_t;

  function automatic cache_line_off_t line_addr(line_idx_t idx, beat_t beat);
    return {idx, beat};
  endfunction

endpackage

// File: rtl/dat_line_xfer_if.sv
// Request, refill, write-back and data-RAM command signals of the line-transfer sequencer.
// The slave modport is the sequencer's view; master is the surrounding cache/RAM view.
interface dat_line_xfer_if;
  import dat_line_xfer_pkg::*;

  logic                    req_vld;
  logic                    req_rdy;
  xfer_op_t                req_op;
  way_sel_t                req_way;
  line_idx_t               req_idx;

  logic                    fill_vld;
  ram_word_t               fill_dat;
  logic                    fill_rdy;

  logic                    evict_vld;
  ram_word_t               evict_dat;
  logic                    evict_last;
  logic                    evict_rdy;

  logic                    done;

  way_sel_t                ram_en;
  way_sel_t                ram_wen;
  cache_line_off_t         ram_addr;
  ram_word_t               ram_wdata;
  logic [WAYS_N*DAT_W-1:0] ram_rdata;

  modport slave (
    input  req_vld, req_op, req_way, req_idx,
    input  fill_vld, fill_dat,
    input  evict_rdy,
    input  ram_rdata,
    output req_rdy, fill_rdy,
    output evict_vld, evict_dat, evict_last,
    output done,
    output ram_en, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output req_vld, req_op, req_way, req_idx,
    output fill_vld, fill_dat,
    output evict_rdy,
    output ram_rdata,
    input  req_rdy, fill_rdy,
    input  evict_vld, evict_dat, evict_last,
    input  done,
    input  ram_en, ram_wen, ram_addr, ram_wdata
  );

endinterface

// File: rtl/xfer_skid_fifo.sv
// Two-entry synchronous FIFO with simultaneous push/pop; flushed by synchronous reset.
// Shared by the line-transfer sequencer and the write-back path.
module xfer_skid_fifo #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != 2'd0);
    // A full FIFO can still take a push when the head leaves in the same cycle.
    do_push = push && ((cnt_q != 2'd2) || do_pop);
  end

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign rdata = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  no_overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
    else $error("xfer_skid_fifo: push into full FIFO");

endmodule

// File: rtl/dat_line_xfer.sv
// Line-transfer sequencer: fills a way from the refill stream or evicts a way onto the
// write-back stream, one line at a time, as sole master of the per-way data RAM port.
module dat_line_xfer
  import dat_line_xfer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  dat_line_xfer_if.slave         bus
);

  xfer_state_t state_q, state_d;
  way_sel_t    way_q, way_d;
  line_idx_t   idx_q, idx_d;
  beat_cnt_t   wr_beat_q, wr_beat_d;
  beat_cnt_t   rd_beat_q, rd_beat_d;
  beat_cnt_t   out_beat_q, out_beat_d;
  logic        rd_pend_q, rd_pend_d;
  logic        done_q, done_d;

  ram_word_t   rd_word;
  ram_word_t   fifo_head;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [1:0]  occupancy;

  // AND-OR select keeps a zero way mask returning zero data.
  always_comb begin
    rd_word = '0;
    for (int unsigned w = 0; w < WAYS_N; w++) begin
      rd_word |= bus.ram_rdata[w*DAT_W +: DAT_W] & {DAT_W{way_q[w]}};
    end
  end

  always_comb begin
    state_d        = state_q;
    way_d          = way_q;
    idx_d          = idx_q;
    wr_beat_d      = wr_beat_q;
    rd_beat_d      = rd_beat_q;
    out_beat_d     = out_beat_q;
    rd_pend_d      = 1'b0;
    done_d         = 1'b0;
    fifo_push      = 1'b0;
    fifo_pop       = 1'b0;
    occupancy      = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    bus.req_rdy    = 1'b0;
    bus.fill_rdy   = 1'b0;
    bus.evict_vld  = 1'b0;
    bus.evict_dat  = '0;
    bus.evict_last = 1'b0;
    bus.ram_en     = '0;
    bus.ram_wen    = '0;
    bus.ram_addr   = '0;
    bus.ram_wdata  = '0;

    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          bus.req_rdy = 1'b1;
          if (bus.req_vld) begin
            way_d      = bus.req_way;
            idx_d      = bus.req_idx;
            wr_beat_d  = '0;
            rd_beat_d  = '0;
            out_beat_d = '0;
            state_d    = (bus.req_op == OpEvict) ? StEvict : StFill;
          end
        end

        StFill: begin
          bus.fill_rdy = 1'b1;
          if (bus.fill_vld) begin
            bus.ram_en    = way_q;
            bus.ram_wen   = way_q;
            bus.ram_addr  = line_addr(idx_q, beat_t'(wr_beat_q));
            bus.ram_wdata = bus.fill_dat;
            wr_beat_d     = wr_beat_q + beat_cnt_t'(1);
            if (wr_beat_q == beat_cnt_t'(BEATS_N - 1)) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end

        StEvict: begin
          // Credit of two: buffered beats plus the read in flight must leave room.
          if ((rd_beat_q < beat_cnt_t'(BEATS_N)) && ((occupancy + {1'b0, rd_pend_q}) < 2'd2)) begin
            bus.ram_en   = way_q;
            bus.ram_addr = line_addr(idx_q, beat_t'(rd_beat_q));
            rd_beat_d    = rd_beat_q + beat_cnt_t'(1);
            rd_pend_d    = 1'b1;
          end

          // Returning read data bypasses an empty FIFO so a line streams at one beat per cycle.
          bus.evict_vld  = !fifo_empty || rd_pend_q;
          bus.evict_dat  = fifo_empty ? rd_word : fifo_head;
          bus.evict_last = bus.evict_vld && (out_beat_q == beat_cnt_t'(BEATS_N - 1));
          fifo_push      = rd_pend_q && !(fifo_empty && bus.evict_rdy);

          if (bus.evict_vld && bus.evict_rdy) begin
            fifo_pop   = !fifo_empty;
            out_beat_d = out_beat_q + beat_cnt_t'(1);
            if (bus.evict_last) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.done = done_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      way_q      <= '0;
      idx_q      <= '0;
      wr_beat_q  <= '0;
      rd_beat_q  <= '0;
      out_beat_q <= '0;
      rd_pend_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      way_q      <= way_d;
      idx_q      <= idx_d;
      wr_beat_q  <= wr_beat_d;
      rd_beat_q  <= rd_beat_d;
      out_beat_q <= out_beat_d;
      rd_pend_q  <= rd_pend_d;
      done_q     <= done_d;
    end
  end

  xfer_skid_fifo #(
    .Width (DAT_W)
  ) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (rd_word),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  req_way_onehot0_a: assert property (@(posedge clk) disable iff (rst)
      (bus.req_vld && bus.req_rdy) |-> $onehot0(bus.req_way))
    else $error("dat_line_xfer: multi-hot req_way");

endmodule

// File: tb/tb_dat_line_xfer.sv
// Scoreboard bench for dat_line_xfer: stimulus queues expected RAM commands, evict beats
// and done cycles; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dat_line_xfer;
  import dat_line_xfer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dat_line_xfer_if bus ();

  dat_line_xfer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural per-way RAM, read data valid the cycle after the enable.
  ram_word_t mem [WAYS_N][2**ADDR_W];
  ram_word_t rdata_q [WAYS_N];

  always @(posedge clk) begin
    for (int w = 0; w < WAYS_N; w++) begin
      if (bus.ram_en[w]) begin
        if (bus.ram_wen[w]) mem[w][bus.ram_addr] <= bus.ram_wdata;
        else                rdata_q[w] <= mem[w][bus.ram_addr];
      end
    end
  end

  for (genvar w = 0; w < WAYS_N; w++) begin : g_rdata
    assign bus.ram_rdata[w*DAT_W +: DAT_W] = rdata_q[w];
  end

  typedef struct packed {
    way_sel_t        way;
    logic            wen;
    cache_line_off_t addr;
    ram_word_t       dat;
  } ram_cmd_t;

  typedef struct packed {
    ram_word_t dat;
    logic      last;
  } beat_exp_t;

  ram_cmd_t  exp_ram[$];
  beat_exp_t exp_beat[$];
  int        exp_done[$];
  int        pop_cyc[$];
  int        checks = 0;
  int        errors = 0;
  int        issued_n = 0;
  int        popped_n = 0;
  int        pat[6] = '{1, 0, 0, 1, 0, 1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    ram_cmd_t  rc;
    beat_exp_t be;
    if (rst) begin
      issued_n = 0;
      popped_n = 0;
    end else begin
      if (bus.ram_en != '0 || bus.ram_wen != '0) begin
        if (exp_ram.size() == 0) begin
          unexpected("ram_cmd_unexpected");
        end else begin
          rc = exp_ram.pop_front();
          check("ram_cmd",
                {16'h0, bus.ram_en, bus.ram_wen, bus.ram_addr,
                 ((|bus.ram_wen) ? bus.ram_wdata : 32'h0)},
                {16'h0, rc.way, (rc.wen ? rc.way : 4'h0), rc.addr, rc.dat});
          if (!rc.wen) begin
            check("rd_outstanding_lt2", 64'(issued_n - popped_n < 2), 64'd1);
            issued_n++;
          end
        end
      end
      if (bus.evict_vld && bus.evict_rdy) begin
        if (exp_beat.size() == 0) begin
          unexpected("evict_beat_unexpected");
        end else begin
          be = exp_beat.pop_front();
          check("evict_beat", {31'h0, bus.evict_dat, bus.evict_last}, {31'h0, be.dat, be.last});
          if (be.last) exp_done.push_back(cyc + 1);
        end
        pop_cyc.push_back(cyc);
        popped_n++;
      end
      if (bus.done) begin
        if (exp_done.size() == 0) unexpected("done_unexpected");
        else                      check("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cache_line_off_t addr_of(input int idx, input int b);
    return cache_line_off_t'(idx * BEATS_N + b);
  endfunction

  task automatic push_fill(input way_sel_t way, input int idx, input ram_word_t base);
    for (int b = 0; b < BEATS_N; b++)
      exp_ram.push_back('{way: way, wen: 1'b1, addr: addr_of(idx, b), dat: base + ram_word_t'(b)});
  endtask

  task automatic push_evict(input way_sel_t way, input int idx, input ram_word_t base);
    for (int b = 0; b < BEATS_N; b++) begin
      exp_ram.push_back('{way: way, wen: 1'b0, addr: addr_of(idx, b), dat: 32'h0});
      exp_beat.push_back('{dat: base + ram_word_t'(b), last: (b == BEATS_N - 1)});
    end
  endtask

  task automatic do_req(input xfer_op_t op, input way_sel_t way, input int idx, output int hs_cyc);
    int n = 0;
    bus.req_vld = 1'b1;
    bus.req_op  = op;
    bus.req_way = way;
    bus.req_idx = line_idx_t'(idx);
    @(negedge clk);
    while (!bus.req_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", 64'(bus.req_rdy), 64'd1);
    hs_cyc = cyc;
    tick();
    bus.req_vld = 1'b0;
  endtask

  task automatic fill_line(input ram_word_t base, input int gap_after, input int gap_len,
                           output int last_cyc);
    for (int b = 0; b < BEATS_N; b++) begin
      int n = 0;
      if (b == gap_after + 1) repeat (gap_len) tick();
      bus.fill_vld = 1'b1;
      bus.fill_dat = base + ram_word_t'(b);
      @(negedge clk);
      while (!bus.fill_rdy && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("fill_accept", 64'(bus.fill_rdy), 64'd1);
      if (b == BEATS_N - 1) begin
        last_cyc = cyc;
        exp_done.push_back(cyc + 1);
      end
      tick();
      bus.fill_vld = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_ram.size() != 0 || exp_beat.size() != 0 || exp_done.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_ram.size() + exp_beat.size() + exp_done.size()), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int last_c;
    bus.req_vld   = 1'b0;
    bus.req_op    = OpFill;
    bus.req_way   = '0;
    bus.req_idx   = '0;
    bus.fill_vld  = 1'b0;
    bus.fill_dat  = '0;
    bus.evict_rdy = 1'b1;
    for (int b = 0; b < BEATS_N; b++) begin
      mem[0][addr_of(3, b)] <= 32'h10 + ram_word_t'(b);
      mem[1][addr_of(7, b)] <= 32'h70 + ram_word_t'(b);
    end

    // Reset: all outputs low while rst is high, idle afterwards.
    tick();
    @(negedge clk);
    check("rst_req_rdy", 64'(bus.req_rdy), 64'd0);
    check("rst_evict_vld", 64'(bus.evict_vld), 64'd0);
    check("rst_ram_en", 64'(bus.ram_en), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_rdy", 64'(bus.req_rdy), 64'd1);
    check("idle_fill_rdy", 64'(bus.fill_rdy), 64'd0);
    check("idle_done", 64'(bus.done), 64'd0);
    tick();

    // Fill way 2, idx 5, back-to-back beats.
    push_fill(4'b0100, 5, 32'hA0);
    do_req(OpFill, 4'b0100, 5, hs);
    fill_line(32'hA0, -10, 0, last_c);
    wait_idle("fill_b2b_idle");

    // Fill with a 3-cycle gap between beats 1 and 2.
    push_fill(4'b0100, 5, 32'hC0);
    do_req(OpFill, 4'b0100, 5, hs);
    fill_line(32'hC0, 1, 3, last_c);
    wait_idle("fill_gap_idle");

    // Evict way 0, idx 3, write-back always ready.
    pop_cyc.delete();
    push_evict(4'b0001, 3, 32'h10);
    do_req(OpEvict, 4'b0001, 3, hs);
    @(negedge clk);
    check("evict_vld_hs_plus1", 64'(bus.evict_vld), 64'd0);
    @(negedge clk);
    check("evict_vld_hs_plus2", 64'(bus.evict_vld), 64'd1);
    wait_idle("evict_full_rate_idle");
    check("evict_first_cycle", 64'(pop_cyc.size() > 0 ? pop_cyc[0] : -1), 64'(hs + 2));
    check("evict_beat_spacing",
          64'(pop_cyc.size() == BEATS_N ? pop_cyc[BEATS_N-1] - pop_cyc[0] : -1), 64'(BEATS_N - 1));

    // Evict under toggling back-pressure.
    push_evict(4'b0001, 3, 32'h10);
    bus.evict_rdy = 1'b0;
    do_req(OpEvict, 4'b0001, 3, hs);
    for (int i = 0; i < 60 && (exp_beat.size() != 0 || exp_done.size() != 0); i++) begin
      bus.evict_rdy = logic'(pat[i % 6]);
      tick();
    end
    bus.evict_rdy = 1'b1;
    wait_idle("evict_bp_idle");

    // Reset after two of four evict beats; then a fresh fill.
    pop_cyc.delete();
    push_evict(4'b0010, 7, 32'h70);
    do_req(OpEvict, 4'b0010, 7, hs);
    for (int n = 0; n < 20 && pop_cyc.size() < 2; n++) @(negedge clk);
    check("rst_mid_two_beats", 64'(pop_cyc.size()), 64'd2);
    tick();
    rst = 1'b1;
    exp_ram.delete();
    exp_beat.delete();
    exp_done.delete();
    @(negedge clk);
    check("rst_mid_req_rdy_low", 64'(bus.req_rdy), 64'd0);
    check("rst_mid_evict_vld_low", 64'(bus.evict_vld), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_evict_vld", 64'(bus.evict_vld), 64'd0);
    check("post_rst_req_rdy", 64'(bus.req_rdy), 64'd1);
    check("post_rst_done", 64'(bus.done), 64'd0);
    tick();
    push_fill(4'b0001, 9, 32'hB0);
    do_req(OpFill, 4'b0001, 9, hs);
    fill_line(32'hB0, -10, 0, last_c);
    wait_idle("post_rst_fill_idle");

    // Fill then evict the same line back-to-back.
    push_fill(4'b1000, 10, 32'hD0);
    do_req(OpFill, 4'b1000, 10, hs);
    fill_line(32'hD0, -10, 0, last_c);
    push_evict(4'b1000, 10, 32'hD0);
    do_req(OpEvict, 4'b1000, 10, hs);
    check("b2b_accept_on_done", 64'(hs), 64'(last_c + 1));
    wait_idle("b2b_evict_idle");

    repeat (3) tick();
    check("final_queues_empty", 64'(exp_ram.size() + exp_beat.size() + exp_done.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
